// File: rtl/booth_mult_r4.sv
// Sequential signed multiplier, radix-4 modified Booth, two multiplier bits per cycle; 17 cycles start-to-result.
// No backpressure: result_rdy is a one-cycle pulse and a new ctrl_mult strobe restarts at any time.
module booth_mult_r4 #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic             ctrl_mult,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic [WIDTH-1:0] result,
   output logic             exception,
   output logic             result_rdy,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] LAST_ITER = 4'(WIDTH / 2 - 1);

   state_t           state, state_nxt;
   logic [WIDTH+1:0] hi, m, m2, sel, sum;
   logic [WIDTH+1:0] hi_n;
   logic [WIDTH-1:0] lo, lo_n;
   logic             q, q_n;
   logic             exc_n;
   logic [3:0]       cnt;

   assign m2 = m << 1;

   always_comb begin
      sel = '0;
      case ({lo[1:0], q})
         3'b001, 3'b010: sel = m;
         3'b011:         sel = m2;
         3'b100:         sel = -m2;
         3'b101, 3'b110: sel = -m;
         default:        sel = '0;
      endcase
   end

   // Add then arithmetic shift {hi,lo,q} right by two.
   always_comb begin
      sum   = hi + sel;
      hi_n  = {{2{sum[WIDTH+1]}}, sum[WIDTH+1:2]};
      lo_n  = {sum[1:0], lo[WIDTH-1:2]};
      q_n   = lo[1];
      exc_n = (hi_n[WIDTH-1:0] != {WIDTH{lo_n[WIDTH-1]}});
   end

   always_comb begin
      state_nxt = state;
      if (ctrl_mult) begin
         state_nxt = RUN;
      end else begin
         case (state)
            RUN:     if (cnt == LAST_ITER) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!clrn) begin
         state      <= IDLE;
         cnt        <= '0;
         hi         <= '0;
         lo         <= '0;
         q          <= 1'b0;
         m          <= '0;
         result     <= '0;
         exception  <= 1'b0;
         result_rdy <= 1'b0;
      end else begin
         state      <= state_nxt;
         result_rdy <= 1'b0;
         if (ctrl_mult) begin
            hi  <= '0;
            lo  <= operand_b;
            q   <= 1'b0;
            m   <= {{2{operand_a[WIDTH-1]}}, operand_a};
            cnt <= '0;
         end else if (state == RUN) begin
            hi  <= hi_n;
            lo  <= lo_n;
            q   <= q_n;
            cnt <= cnt + 4'd1;
            if (cnt == LAST_ITER) begin
               result     <= lo_n;
               exception  <= exc_n;
               result_rdy <= 1'b1;
            end
         end
      end
   end

   assign busy = (state == RUN);

endmodule

// File: tb/tb_booth_mult_r4.sv
// Directed and random checks of booth_mult_r4 against a plain 64-bit product model.
module tb_booth_mult_r4;

   logic        clk = 1'b0;
   logic        clrn;
   logic        ctrl_mult;
   logic [31:0] operand_a, operand_b;
   logic [31:0] result;
   logic        exception, result_rdy, busy;

   int nchecks = 0;
   int nerrors = 0;
   bit check_en = 1'b0;
   int busy_cycles = 0;
   int rdy_pulses = 0;

   // model state
   longint m_prod;
   int     m_left = 0;
   bit     m_busy = 0, m_rdy = 0, m_exc = 0;
   logic [31:0] m_res = '0;
   localparam longint LIM_HI = 64'sd2147483647;
   localparam longint LIM_LO = -64'sd2147483648;

   booth_mult_r4 #(.WIDTH(32)) dut (
      .clk(clk), .clrn(clrn), .ctrl_mult(ctrl_mult),
      .operand_a(operand_a), .operand_b(operand_b),
      .result(result), .exception(exception),
      .result_rdy(result_rdy), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nchecks++;
      if (act !== exp) begin
         nerrors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a start captures the true product; 16 edges later it is reported.
   always @(posedge clk) begin
      if (!clrn) begin
         m_busy = 0; m_rdy = 0; m_res = '0; m_exc = 0; m_left = 0;
      end else if (ctrl_mult) begin
         m_prod = longint'($signed(operand_a)) * longint'($signed(operand_b));
         m_busy = 1; m_left = 16; m_rdy = 0;
      end else if (m_busy) begin
         m_left--;
         m_rdy = 0;
         if (m_left == 0) begin
            m_busy = 0;
            m_rdy  = 1;
            m_res  = m_prod[31:0];
            m_exc  = (m_prod > LIM_HI) || (m_prod < LIM_LO);
         end
      end else begin
         m_rdy = 0;
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         chk("cyc_result", {32'd0, result}, {32'd0, m_res});
         chk("cyc_exception", {63'd0, exception}, {63'd0, m_exc});
         chk("cyc_result_rdy", {63'd0, result_rdy}, {63'd0, m_rdy});
         chk("cyc_busy", {63'd0, busy}, {63'd0, m_busy});
      end
      if (busy === 1'b1) busy_cycles++;
      if (result_rdy === 1'b1) rdy_pulses++;
   end

   task automatic do_start(input logic [31:0] a, input logic [31:0] b);
      @(negedge clk); #1;
      operand_a = a; operand_b = b; ctrl_mult = 1'b1;
      @(negedge clk); #1;
      ctrl_mult = 1'b0;
      operand_a = $urandom;
      operand_b = $urandom;
   endtask

   // Returns the consumer edge (counted from the start edge) at which result_rdy is seen.
   task automatic wait_result(output int edges);
      int cyc = 0;
      edges = -1;
      while (cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (result_rdy === 1'b1) begin
            edges = cyc + 1;
            break;
         end
      end
      if (edges < 0) begin
         nchecks++; nerrors++;
         $display("FAIL wait_result: result_rdy not seen within 40 cycles");
      end
   endtask

   task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_res, input logic exp_exc);
      int edges;
      do_start(a, b);
      wait_result(edges);
      chk({name, "_latency"}, 64'(edges), 64'd17);
      chk({name, "_result"}, {32'd0, result}, {32'd0, exp_res});
      chk({name, "_exception"}, {63'd0, exception}, {63'd0, exp_exc});
      chk({name, "_model"}, {31'd0, m_exc, m_res}, {31'd0, exp_exc, exp_res});
   endtask

   initial begin
      int edges;
      logic [31:0] corners [6];
      logic [31:0] ra, rb;
      corners[0] = 32'h8000_0000; corners[1] = 32'h7FFF_FFFF; corners[2] = 32'hFFFF_FFFF;
      corners[3] = 32'h0000_0000; corners[4] = 32'h0000_0001; corners[5] = 32'h0001_0000;

      clrn = 1'b0; ctrl_mult = 1'b0; operand_a = '0; operand_b = '0;
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      chk("reset_result", {32'd0, result}, 64'd0);
      chk("reset_exception", {63'd0, exception}, 64'd0);
      chk("reset_rdy", {63'd0, result_rdy}, 64'd0);
      chk("reset_busy", {63'd0, busy}, 64'd0);
      check_en = 1'b1;
      #1 clrn = 1'b1;

      // 3 x 4 with busy width and single-cycle pulse
      busy_cycles = 0;
      directed("t1_3x4", 32'd3, 32'd4, 32'd12, 1'b0);
      chk("t1_busy_cycles", 64'(busy_cycles), 64'd16);
      @(negedge clk);
      chk("t1_rdy_single", {63'd0, result_rdy}, 64'd0);
      chk("t1_result_hold", {32'd0, result}, 64'd12);

      directed("t2_m7x6", 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFD6, 1'b0);
      directed("t2_min_x1", 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0);
      directed("t3_max_x2", 32'h7FFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b1);
      directed("t3_min_xm1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
      directed("zero_op", 32'd0, 32'd12345, 32'd0, 1'b0);
      directed("min_x_min", 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1);

      // restart mid-operation: 81 must never be reported
      rdy_pulses = 0;
      do_start(32'd9, 32'd9);
      repeat (3) @(negedge clk);
      directed("t4_restart", 32'd5, 32'd5, 32'd25, 1'b0);
      chk("t4_single_pulse", 64'(rdy_pulses), 64'd1);

      // synchronous reset mid-operation
      do_start(32'd100, 32'd100);
      repeat (6) @(negedge clk);
      #1 clrn = 1'b0;
      @(negedge clk);
      chk("t5_busy", {63'd0, busy}, 64'd0);
      chk("t5_result", {32'd0, result}, 64'd0);
      #1 clrn = 1'b1;
      rdy_pulses = 0;
      repeat (25) @(negedge clk);
      chk("t5_no_rdy", 64'(rdy_pulses), 64'd0);

      // ctrl_mult held high: never completes
      @(negedge clk); #1;
      operand_a = 32'd7; operand_b = 32'd7; ctrl_mult = 1'b1;
      rdy_pulses = 0;
      repeat (20) @(negedge clk);
      #1 ctrl_mult = 1'b0;
      chk("held_no_rdy", 64'(rdy_pulses), 64'd0);
      wait_result(edges);
      chk("held_release_latency", 64'(edges), 64'd17);
      chk("held_release_result", {32'd0, result}, 64'd49);

      // random pairs, with corner values mixed in
      for (int i = 0; i < 1000; i++) begin
         ra = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
         rb = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
         do_start(ra, rb);
         wait_result(edges);
         chk("rand_latency", 64'(edges), 64'd17);
      end

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

endmodule
